alu_result_fifo: RTL and testbench

//  Output stage directly downstream of the ALU function units (arith, logic, compare, shift).
//  - Each cycle, selects the one unit whose result-valid flag is set.
//  - Pushes that unit's result into a small synchronous FIFO.
//  - Presents buffered results to the consumer (register file / UART TX path) over valid/ready.
//  - Decouples single-cycle ALU result pulses from a consumer that may stall.

---
 rtl/alu_result_fifo.sv | 116 +++++++++++
 tb/tb_alu_result_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// ALU result output stage: a fixed-priority select feeding a first-word-fall-through FIFO with a valid/ready read side.
// Optional build macro ALU_SRC_TAG_EN adds OUT_SRC, which reports the unit that produced each entry.
module alu_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [WIDTH-1:0]       ARITH_OUT,
    input  logic                   Arith_Flag,
    input  logic [WIDTH-1:0]       Logic_OUT,
    input  logic                   Logic_Flag,
    input  logic [WIDTH-1:0]       CMP_OUT,
    input  logic                   CMP_Flag,
    input  logic [WIDTH-1:0]       SHIFT_OUT,
    input  logic                   SHIFT_Flag,
    output logic [WIDTH-1:0]       OUT_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [$clog2(DEPTH):0] OUT_COUNT,
    output logic                   OVERFLOW,
    input  logic                   CLR_OVF,
`ifdef ALU_SRC_TAG_EN
    output logic [1:0]             OUT_SRC,
`endif
    output logic                   COLLISION
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [3:0]       flags;
    logic [WIDTH-1:0] win_data;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             accept;
    logic             drop;
    logic             multi;

    assign flags = {Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag};

    always_comb begin
        win_data = SHIFT_OUT;
        if (Arith_Flag)
            win_data = ARITH_OUT;
        else if (Logic_Flag)
            win_data = Logic_OUT;
        else if (CMP_Flag)
            win_data = CMP_OUT;
    end

    // The extra pointer MSB separates full from empty when the slot bits match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push   = |flags;
    assign pop    = ~empty & OUT_READY;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;
    assign multi  = (flags & (flags - 4'd1)) != 4'd0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            OVERFLOW  <= 1'b0;
            COLLISION <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (drop)
                OVERFLOW <= 1'b1;
            else if (CLR_OVF)
                OVERFLOW <= 1'b0;
            COLLISION <= multi;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept && !RST)
            mem[wr_ptr[AW-1:0]] <= win_data;
    end

    assign OUT_VALID = ~empty;
    assign OUT_COUNT = wr_ptr - rd_ptr;
    assign OUT_DATA  = empty ? '0 : mem[rd_ptr[AW-1:0]];

`ifdef ALU_SRC_TAG_EN
    logic [1:0] win_src;
    logic [1:0] src_mem [DEPTH];

    always_comb begin
        win_src = 2'd3;
        if (Arith_Flag)
            win_src = 2'd0;
        else if (Logic_Flag)
            win_src = 2'd1;
        else if (CMP_Flag)
            win_src = 2'd2;
    end

    always_ff @(posedge CLK) begin
        if (accept && !RST)
            src_mem[wr_ptr[AW-1:0]] <= win_src;
    end

    assign OUT_SRC = empty ? 2'd0 : src_mem[rd_ptr[AW-1:0]];
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: a vector table covering reset, fill, overflow, push-with-pop and collision,
// followed by a wrap sequence that is checked against a queue model.
module tb_alu_result_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic [WIDTH-1:0]  ARITH_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT;
    logic              Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
    logic [WIDTH-1:0]  OUT_DATA;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [2:0]        OUT_COUNT;
    logic              OVERFLOW;
    logic              CLR_OVF;
    logic              COLLISION;
`ifdef ALU_SRC_TAG_EN
    logic [1:0]        OUT_SRC;
`endif

    int num_vectors = 0;
    int num_miscompares = 0;

    always #5 CLK = ~CLK;

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .ARITH_OUT(ARITH_OUT), .Arith_Flag(Arith_Flag),
        .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
        .SHIFT_OUT(SHIFT_OUT), .SHIFT_Flag(SHIFT_Flag),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_COUNT(OUT_COUNT), .OVERFLOW(OVERFLOW), .CLR_OVF(CLR_OVF),
`ifdef ALU_SRC_TAG_EN
        .OUT_SRC(OUT_SRC),
`endif
        .COLLISION(COLLISION)
    );

    // flags bit order: [3]=arith [2]=logic [1]=cmp [0]=shift
    typedef struct {
        logic             rst;
        logic [3:0]       flags;
        logic [WIDTH-1:0] a, l, c, s;
        logic             ready, clr;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic [2:0]       exp_count;
        logic             exp_ovf, exp_coll;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [3:0] flags, logic [15:0] a, logic [15:0] l,
                                logic [15:0] c, logic [15:0] s, logic ready, logic clr,
                                logic ev, logic [15:0] ed, logic [2:0] ec, logic eo, logic ecol);
        vec_t v;
        v.rst = rst; v.flags = flags; v.a = a; v.l = l; v.c = c; v.s = s;
        v.ready = ready; v.clr = clr;
        v.exp_valid = ev; v.exp_data = ed; v.exp_count = ec; v.exp_ovf = eo; v.exp_coll = ecol;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [3:0] flags, input logic [15:0] a,
                                 input logic [15:0] l, input logic [15:0] c, input logic [15:0] s,
                                 input logic ready, input logic clr);
        RST = rst;
        Arith_Flag = flags[3]; Logic_Flag = flags[2]; CMP_Flag = flags[1]; SHIFT_Flag = flags[0];
        ARITH_OUT = a; Logic_OUT = l; CMP_OUT = c; SHIFT_OUT = s;
        OUT_READY = ready;
        CLR_OVF = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [15:0] ed,
                               input logic [2:0] ec, input logic eo, input logic ecol);
        num_vectors++;
        if ({OUT_VALID, OUT_DATA, OUT_COUNT, OVERFLOW, COLLISION} !== {ev, ed, ec, eo, ecol}) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got valid=%0b data=%h count=%0d ovf=%0b coll=%0b, expected valid=%0b data=%h count=%0d ovf=%0b coll=%0b",
                     name, OUT_VALID, OUT_DATA, OUT_COUNT, OVERFLOW, COLLISION, ev, ed, ec, eo, ecol);
        end
    endtask

    initial begin
        logic [15:0] q[$];
        logic        model_ovf;
        logic        push, ready, do_pop;
        logic [15:0] val;
        int          guard;

        // T1 reset with a flag present
        vecs.push_back(mk(1, 4'b0100, 0, 16'h00AA, 0, 0, 0, 0,   0, 16'h0000, 0, 0, 0));
        // T2 single push, hold, then pop
        vecs.push_back(mk(0, 4'b0100, 0, 16'h00F0, 0, 0, 0, 0,   1, 16'h00F0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0,          1, 16'h00F0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0,          0, 16'h0000, 0, 0, 0));
        // T3 fill 1..4, fifth push overflows, drain, clear
        vecs.push_back(mk(0, 4'b1000, 16'd1, 0, 0, 0, 0, 0,      1, 16'd1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b1000, 16'd2, 0, 0, 0, 0, 0,      1, 16'd1, 2, 0, 0));
        vecs.push_back(mk(0, 4'b1000, 16'd3, 0, 0, 0, 0, 0,      1, 16'd1, 3, 0, 0));
        vecs.push_back(mk(0, 4'b1000, 16'd4, 0, 0, 0, 0, 0,      1, 16'd1, 4, 0, 0));
        vecs.push_back(mk(0, 4'b1000, 16'd5, 0, 0, 0, 0, 0,      1, 16'd1, 4, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0,          1, 16'd2, 3, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0,          1, 16'd3, 2, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0,          1, 16'd4, 1, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0,          0, 16'd0, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1,          0, 16'd0, 0, 0, 0));
        // T4 full, push and pop together
        vecs.push_back(mk(0, 4'b0010, 0, 0, 16'd1, 0, 0, 0,      1, 16'd1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0010, 0, 0, 16'd2, 0, 0, 0,      1, 16'd1, 2, 0, 0));
        vecs.push_back(mk(0, 4'b0010, 0, 0, 16'd3, 0, 0, 0,      1, 16'd1, 3, 0, 0));
        vecs.push_back(mk(0, 4'b0010, 0, 0, 16'd4, 0, 0, 0,      1, 16'd1, 4, 0, 0));
        vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 16'd9, 1, 0,      1, 16'd2, 4, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0,          1, 16'd3, 3, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0,          1, 16'd4, 2, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0,          1, 16'd9, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0,          0, 16'd0, 0, 0, 0));
        // T5 collision: arith wins, pulse lasts one cycle
        vecs.push_back(mk(0, 4'b1001, 16'h0011, 0, 0, 16'h0022, 0, 0, 1, 16'h0011, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0,          1, 16'h0011, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0,          0, 16'h0000, 0, 0, 0));
        // Overflow set beats a same-cycle clear, then reset overrides a push
        vecs.push_back(mk(0, 4'b0100, 0, 16'h10, 0, 0, 0, 0,     1, 16'h10, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 0, 16'h11, 0, 0, 0, 0,     1, 16'h10, 2, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 0, 16'h12, 0, 0, 0, 0,     1, 16'h10, 3, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 0, 16'h13, 0, 0, 0, 0,     1, 16'h10, 4, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 0, 16'h14, 0, 0, 0, 1,     1, 16'h10, 4, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1,          1, 16'h10, 4, 0, 0));
        vecs.push_back(mk(1, 4'b0100, 0, 16'h55, 0, 0, 1, 0,     0, 16'h00, 0, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].flags, vecs[i].a, vecs[i].l, vecs[i].c, vecs[i].s,
                          vecs[i].ready, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                        vecs[i].exp_count, vecs[i].exp_ovf, vecs[i].exp_coll);
`ifdef ALU_SRC_TAG_EN
            if (i == 23) begin
                num_vectors++;
                if (OUT_SRC !== 2'd0) begin
                    num_miscompares++;
                    $display("[TB] FAIL src_tag: got %0d, expected 0", OUT_SRC);
                end
            end
`endif
        end

        // T6 wrap: pushes every other cycle with an irregular stall, checked against a queue model
        model_ovf = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push  = (i % 2 == 0);
            ready = (i % 3 != 2);
            val   = 16'h0100 + 16'(i);
            do_pop = (q.size() > 0) && ready;
            if (do_pop)
                void'(q.pop_front());
            if (push && (q.size() < DEPTH))
                q.push_back(val);
            else if (push)
                model_ovf = 1'b1;
            applyStimulus(0, {1'b0, push, 2'b00}, 0, val, 0, 0, ready, 0);
            checkOutput($sformatf("wrap%0d", i), q.size() != 0, (q.size() != 0) ? q[0] : 16'h0,
                        3'(q.size()), model_ovf, 0);
        end
        guard = 0;
        while (q.size() > 0 && guard < 8) begin
            void'(q.pop_front());
            applyStimulus(0, 4'b0000, 0, 0, 0, 0, 1, 0);
            checkOutput($sformatf("drain%0d", guard), q.size() != 0, (q.size() != 0) ? q[0] : 16'h0,
                        3'(q.size()), model_ovf, 0);
            guard++;
        end
        num_vectors++;
        if (OUT_VALID !== 1'b0) begin
            num_miscompares++;
            $display("[TB] FAIL final_empty: got valid=%0b, expected valid=0", OUT_VALID);
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule
